// File: rtl/calc_pkg.sv
// Shared command/response encodings and widths for the N-port calculator engine.
package calc_pkg;

    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_OP2  = 1'b1
    } cap_state_e;

endpackage

// File: rtl/calc_port_q.sv
// One request port: two-cycle capture FSM feeding a QDEPTH-entry FIFO drained by the arbiter.
module calc_port_q
    import calc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2,
    parameter int QDEPTH = 4
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] data,
    input  logic [TAG_W-1:0]  tag,
    input  logic              pop,
    output logic              ready,
    output logic              head_valid,
    output logic [CMD_W-1:0]  head_cmd,
    output logic [DATA_W-1:0] head_op1,
    output logic [DATA_W-1:0] head_op2,
    output logic [TAG_W-1:0]  head_tag
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam logic [PTR_W:0] FULL_CNT = QDEPTH[PTR_W:0];

    cap_state_e state, state_next;
    logic start, push;

    logic [CMD_W-1:0]  cmd_hold;
    logic [DATA_W-1:0] op1_hold;
    logic [TAG_W-1:0]  tag_hold;

    logic [CMD_W-1:0]  q_cmd [QDEPTH];
    logic [DATA_W-1:0] q_op1 [QDEPTH];
    logic [DATA_W-1:0] q_op2 [QDEPTH];
    logic [TAG_W-1:0]  q_tag [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;

    // A pop in the same cycle frees a slot, so a full queue can still accept a new request.
    assign ready = !reset && (state == CAP_IDLE) && ((count < FULL_CNT) || pop);

    assign head_valid = (count != '0);
    assign head_cmd   = q_cmd[rd_ptr];
    assign head_op1   = q_op1[rd_ptr];
    assign head_op2   = q_op2[rd_ptr];
    assign head_tag   = q_tag[rd_ptr];

    always_comb begin
        state_next = state;
        start      = 1'b0;
        push       = 1'b0;
        case (state)
            CAP_IDLE: begin
                if (cmd != '0 && ready) begin
                    start      = 1'b1;
                    state_next = CAP_OP2;
                end
            end
            CAP_OP2: begin
                push       = 1'b1;
                state_next = CAP_IDLE;
            end
            default: state_next = CAP_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state    <= CAP_IDLE;
            cmd_hold <= '0;
            op1_hold <= '0;
            tag_hold <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                cmd_hold <= cmd;
                op1_hold <= data;
                tag_hold <= tag;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        if (push) begin
            q_cmd[wr_ptr] <= cmd_hold;
            q_op1[wr_ptr] <= op1_hold;
            q_op2[wr_ptr] <= data;
            q_tag[wr_ptr] <= tag_hold;
        end
    end

endmodule

// File: rtl/calc_n_engine.sv
// N-port calculator: per-port request queues, round-robin issue, shared registered ALU.
module calc_n_engine
    import calc_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 2,
    parameter int QDEPTH    = 4
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [CMD_W*NUM_PORTS-1:0]  req_cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
    input  logic [TAG_W*NUM_PORTS-1:0]  req_tag_in,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [RESP_W*NUM_PORTS-1:0] out_resp,
    output logic [DATA_W*NUM_PORTS-1:0] out_data,
    output logic [TAG_W*NUM_PORTS-1:0]  out_tag
);

    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int SH_W   = $clog2(DATA_W);

    logic [NUM_PORTS-1:0] head_valid, pop;
    logic [CMD_W-1:0]     head_cmd [NUM_PORTS];
    logic [DATA_W-1:0]    head_op1 [NUM_PORTS];
    logic [DATA_W-1:0]    head_op2 [NUM_PORTS];
    logic [TAG_W-1:0]     head_tag [NUM_PORTS];

    // Handshake: a request starts in a cycle with cmd != 0 and req_ready high; op2 follows
    // on the very next cycle with no ready check, and a cmd seen while req_ready is low is ignored.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        calc_port_q #(.DATA_W(DATA_W), .TAG_W(TAG_W), .QDEPTH(QDEPTH)) u_port (
            .c_clk      (c_clk),
            .reset      (reset),
            .cmd        (req_cmd_in[CMD_W*p +: CMD_W]),
            .data       (req_data_in[DATA_W*p +: DATA_W]),
            .tag        (req_tag_in[TAG_W*p +: TAG_W]),
            .pop        (pop[p]),
            .ready      (req_ready[p]),
            .head_valid (head_valid[p]),
            .head_cmd   (head_cmd[p]),
            .head_op1   (head_op1[p]),
            .head_op2   (head_op2[p]),
            .head_tag   (head_tag[p])
        );
    end

    logic [PORT_W-1:0] rr_ptr, grant;
    logic              grant_valid;

    // Scan from the farthest candidate down so the nearest non-empty port after rr_ptr wins.
    always_comb begin
        int idx;
        grant       = '0;
        grant_valid = 1'b0;
        pop         = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (head_valid[idx]) begin
                grant       = PORT_W'(idx);
                grant_valid = 1'b1;
            end
        end
        if (grant_valid) pop[grant] = 1'b1;
    end

    logic              iss_valid;
    logic [PORT_W-1:0] iss_port;
    logic [CMD_W-1:0]  iss_cmd;
    logic [DATA_W-1:0] iss_op1, iss_op2;
    logic [TAG_W-1:0]  iss_tag;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            iss_valid <= 1'b0;
            iss_port  <= '0;
            iss_cmd   <= '0;
            iss_op1   <= '0;
            iss_op2   <= '0;
            iss_tag   <= '0;
        end else begin
            iss_valid <= grant_valid;
            if (grant_valid) begin
                rr_ptr   <= (grant == PORT_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
                iss_port <= grant;
                iss_cmd  <= head_cmd[grant];
                iss_op1  <= head_op1[grant];
                iss_op2  <= head_op2[grant];
                iss_tag  <= head_tag[grant];
            end
        end
    end

    resp_e             alu_resp;
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W:0]   sum;

    always_comb begin
        alu_resp = RESP_OK;
        alu_data = '0;
        sum      = {1'b0, iss_op1} + {1'b0, iss_op2};
        case (iss_cmd)
            CMD_ADD: if (sum[DATA_W]) alu_resp = RESP_ERR; else alu_data = sum[DATA_W-1:0];
            CMD_SUB: if (iss_op2 > iss_op1) alu_resp = RESP_ERR; else alu_data = iss_op1 - iss_op2;
            CMD_SHL: alu_data = iss_op1 << iss_op2[SH_W-1:0];
            CMD_SHR: alu_data = iss_op1 >> iss_op2[SH_W-1:0];
            default: alu_resp = RESP_ERR;
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            if (iss_valid) begin
                out_resp[RESP_W*iss_port +: RESP_W] <= alu_resp;
                out_data[DATA_W*iss_port +: DATA_W] <= alu_data;
                out_tag[TAG_W*iss_port +: TAG_W]    <= iss_tag;
            end
        end
    end

endmodule

// File: tb/tb_calc_n_engine.sv
// Directed bench for calc_n_engine: per-port expected queues checked by a negedge monitor.
module tb_calc_n_engine;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int QD = 4;
    localparam int EW = 2 + DW + TW;

    logic            c_clk = 1'b0;
    logic            reset = 1'b1;
    logic [4*N-1:0]  req_cmd_in = '0;
    logic [DW*N-1:0] req_data_in = '0;
    logic [TW*N-1:0] req_tag_in = '0;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  out_resp;
    logic [DW*N-1:0] out_data;
    logic [TW*N-1:0] out_tag;

    calc_n_engine #(.NUM_PORTS(N), .DATA_W(DW), .TAG_W(TW), .QDEPTH(QD)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .req_ready   (req_ready),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag)
    );

    // ---------------- clock / counters ----------------
    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[N][$];
    int last_cyc[N];
    int stalls[N];

    // Hand-computed vectors for the loaded run: cmd, op1, op2, resp, data.
    logic [3:0]  t_cmd [8] = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h2, 4'h1, 4'h7, 4'h5};
    logic [31:0] t_op1 [8] = '{32'h1234, 32'h100, 32'h3, 32'hF0, 32'h5, 32'h8000_0000, 32'h9, 32'hFFFF_FFFF};
    logic [31:0] t_op2 [8] = '{32'h1111, 32'h1, 32'h4, 32'd36, 32'h5, 32'h8000_0000, 32'h9, 32'd32};
    logic [1:0]  t_rsp [8] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1};
    logic [31:0] t_dat [8] = '{32'h2345, 32'hFF, 32'h30, 32'hF, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};

    // ---------------- scoreboard monitor ----------------
    logic [EW-1:0] mon_got, mon_exp;
    always @(negedge c_clk) begin
        if (!reset) begin
            for (int p = 0; p < N; p++) begin
                if (out_resp[2*p +: 2] != 2'd0) begin
                    mon_got = {out_resp[2*p +: 2], out_data[DW*p +: DW], out_tag[TW*p +: TW]};
                    last_cyc[p] = cyc;
                    checks++;
                    if (exp_q[p].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp port %0d got %h required none", p, mon_got);
                    end else begin
                        mon_exp = exp_q[p].pop_front();
                        if (mon_got !== mon_exp) begin
                            errors++;
                            $display("FAIL resp port %0d got %h required %h", p, mon_got, mon_exp);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    // Presents cmd every cycle until accepted; cycles seen with req_ready low are dropped requests.
    task automatic send(input int p, input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                        input logic [1:0] tag, input logic [1:0] eresp, input logic [31:0] edata,
                        output int op2_cyc);
        bit done = 1'b0;
        op2_cyc = 0;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge c_clk);
            req_cmd_in[4*p +: 4]    = cmd;
            req_data_in[DW*p +: DW] = op1;
            req_tag_in[TW*p +: TW]  = tag;
            if (req_ready[p]) begin
                exp_q[p].push_back({eresp, edata, tag});
                done = 1'b1;
            end else begin
                stalls[p]++;
            end
        end
        if (!done) begin
            req_cmd_in[4*p +: 4] = 4'h0;
            checks++;
            errors++;
            $display("FAIL ready_timeout port %0d got ready=0 required ready=1", p);
        end else begin
            @(negedge c_clk);
            req_cmd_in[4*p +: 4]    = 4'h0;
            req_data_in[DW*p +: DW] = op2;
            op2_cyc = cyc;
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int p = 0; p < N; p++) s += exp_q[p].size();
        return s;
    endfunction

    task automatic drain();
        int w = 0;
        while (pending() != 0 && w < 500) begin
            @(negedge c_clk);
            w++;
        end
        check("drain_pending", 64'(pending()), 64'd0);
        repeat (3) @(negedge c_clk);
    endtask

    task automatic load_port(input int p);
        int oc;
        int i;
        for (int k = 0; k < 16; k++) begin
            i = (k + p) % 8;
            send(p, t_cmd[i], t_op1[i], t_op2[i], 2'(k), t_rsp[i], t_dat[i], oc);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int oc, got_c;

        // reset state
        repeat (2) @(negedge c_clk);
        check("ready_in_reset", 64'(req_ready), 64'h0);
        check("outputs_in_reset", 64'({out_resp, out_tag}) | 64'(out_data[63:0]), 64'h0);
        repeat (1) @(negedge c_clk);
        reset = 1'b0;
        #1;
        check("ready_after_release", 64'(req_ready), 64'hF);

        // port 0 add: latency and one-cycle pulse
        send(0, 4'h1, 32'h30, 32'h20, 2'd1, 2'd1, 32'h50, oc);
        got_c = -1;
        for (int w = 0; w < 20; w++) begin
            @(negedge c_clk);
            if (out_resp[1:0] != 2'd0) begin
                got_c = cyc;
                break;
            end
        end
        check("add_latency", 64'(got_c), 64'(oc + 3));
        @(negedge c_clk);
        check("pulse_cleared", {out_resp[1:0], out_data[31:0], out_tag[1:0]}, 64'h0);
        drain();

        // port 1 error cases
        send(1, 4'h2, 32'h10, 32'h20, 2'd2, 2'd2, 32'h0, oc);
        send(1, 4'h1, 32'hFFFF_FFFF, 32'h1, 2'd3, 2'd2, 32'h0, oc);
        send(1, 4'h3, 32'h5, 32'h6, 2'd1, 2'd2, 32'h0, oc);
        drain();

        // port 2 shifts
        send(2, 4'h5, 32'h1, 32'h3F, 2'd0, 2'd1, 32'h8000_0000, oc);
        send(2, 4'h6, 32'h8000_0000, 32'h4, 2'd3, 2'd1, 32'h0800_0000, oc);
        drain();

        // one request on port 3 brings the round-robin start back to port 0
        send(3, 4'h1, 32'h7, 32'h8, 2'd2, 2'd1, 32'hF, oc);
        drain();

        // round 1: all ports at once -> 0,1,2,3
        fork
            begin int o; send(0, 4'h1, 32'h00, 32'h1, 2'd0, 2'd1, 32'h01, o); end
            begin int o; send(1, 4'h1, 32'h10, 32'h1, 2'd1, 2'd1, 32'h11, o); end
            begin int o; send(2, 4'h1, 32'h20, 32'h1, 2'd2, 2'd1, 32'h21, o); end
            begin int o; send(3, 4'h1, 32'h30, 32'h1, 2'd3, 2'd1, 32'h31, o); end
        join
        drain();
        check("rr1_order_p1", 64'(last_cyc[1]), 64'(last_cyc[0] + 1));
        check("rr1_order_p2", 64'(last_cyc[2]), 64'(last_cyc[1] + 1));
        check("rr1_order_p3", 64'(last_cyc[3]), 64'(last_cyc[2] + 1));

        // single on port 1 leaves the start at port 2; round 2 -> 2,3,0,1
        send(1, 4'h2, 32'h9, 32'h4, 2'd0, 2'd1, 32'h5, oc);
        drain();
        fork
            begin int o; send(0, 4'h6, 32'h40, 32'h2, 2'd3, 2'd1, 32'h10, o); end
            begin int o; send(1, 4'h5, 32'h40, 32'h2, 2'd2, 2'd1, 32'h100, o); end
            begin int o; send(2, 4'h2, 32'h40, 32'h2, 2'd1, 2'd1, 32'h3E, o); end
            begin int o; send(3, 4'h9, 32'h40, 32'h2, 2'd0, 2'd2, 32'h0, o); end
        join
        drain();
        check("rr2_order_p3", 64'(last_cyc[3]), 64'(last_cyc[2] + 1));
        check("rr2_order_p0", 64'(last_cyc[0]), 64'(last_cyc[3] + 1));
        check("rr2_order_p1", 64'(last_cyc[1]), 64'(last_cyc[0] + 1));

        // continuous load on every port: queues fill and req_ready must drop
        for (int p = 0; p < N; p++) stalls[p] = 0;
        fork
            load_port(0);
            load_port(1);
            load_port(2);
            load_port(3);
        join
        drain();
        for (int p = 0; p < N; p++) check($sformatf("ready_dropped_p%0d", p), 64'(stalls[p] != 0), 64'd1);

        // reset with a partial request on port 0 and entries queued on ports 1..3
        @(negedge c_clk);
        for (int p = 1; p < N; p++) begin
            req_cmd_in[4*p +: 4] = 4'h1;
            req_data_in[DW*p +: DW] = 32'h1;
            req_tag_in[TW*p +: TW] = 2'(p);
        end
        @(negedge c_clk);
        for (int p = 1; p < N; p++) begin
            req_cmd_in[4*p +: 4] = 4'h0;
            req_data_in[DW*p +: DW] = 32'h2;
        end
        req_cmd_in[3:0] = 4'h1;
        req_data_in[31:0] = 32'h7;
        req_tag_in[1:0] = 2'd0;
        @(negedge c_clk);
        req_cmd_in = '0;
        req_data_in = '0;
        reset = 1'b1;
        #1;
        check("ready_mid_reset", 64'(req_ready), 64'h0);
        check("resp_mid_reset", 64'(out_resp), 64'h0);
        repeat (3) @(negedge c_clk);
        reset = 1'b0;
        #1;
        check("ready_after_rereset", 64'(req_ready), 64'hF);
        repeat (12) @(negedge c_clk);
        send(0, 4'h1, 32'h3, 32'h4, 2'd2, 2'd1, 32'h7, oc);
        drain();

        for (int p = 0; p < N; p++) check($sformatf("leftover_p%0d", p), 64'(exp_q[p].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
